// File: rtl/spi_capture_buffer.sv
// Triggered capture buffer behind the SPI byte decoder: waits for a masked trigger byte, then stores
// up to CAPTURE_LEN bytes into a FIFO drained by a host read port. Optional macro: SPI_CAPBUF_DETCOUNT_EN.
module spi_capture_buffer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CAPTURE_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_detected,
  input  logic        arm,
  input  logic [7:0]  trig_value,
  input  logic [7:0]  trig_mask,
  input  logic        rd_en,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  output logic [1:0]  state,
  output logic [15:0] det_count
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [LW-1:0] cap_cnt_q, cap_cnt_d;
  logic          overflow_q, overflow_d;
  logic          empty_q, full_q;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;

  logic          match_c;
  logic          wr_c;
  logic          rd_c;

  assign match_c = ((in_data ^ trig_value) & trig_mask) == '0;

  // Reads need stored data; arm wins over a coincident read.
  assign rd_c = rd_en && !arm && !empty_q;

  // Next-state, capture counter, write/drop decision.
  always_comb begin
    state_d    = state_q;
    cap_cnt_d  = cap_cnt_q;
    overflow_d = overflow_q;
    wr_c       = 1'b0;
    if (arm) begin
      state_d    = S_ARMED;
      cap_cnt_d  = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
        end
        S_ARMED: begin
          if (in_valid && match_c) begin
            wr_c      = 1'b1;
            cap_cnt_d = LW'(1);
            state_d   = (CAPTURE_LEN == 1) ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (in_valid) begin
            cap_cnt_d = cap_cnt_q + LW'(1);
            if (!full_q || rd_c) begin
              wr_c = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
            if (cap_cnt_d == LW'(CAPTURE_LEN)) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pointer and occupancy updates; arm resets the FIFO outright.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (arm) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_c) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_c, rd_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cap_cnt_q  <= '0;
      overflow_q <= 1'b0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cap_cnt_q  <= cap_cnt_d;
      overflow_q <= overflow_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == CW'(DEPTH));
      rd_valid_q <= rd_c;
      if (rd_c) rd_data_q <= mem[rd_ptr_q];
    end
  end

  // Storage array carries no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr_q] <= in_data;
  end

`ifdef SPI_CAPBUF_DETCOUNT_EN
  logic [15:0] det_q;

  // Saturating frame counter, live only while a capture is pending or running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q <= '0;
    end else if (arm) begin
      det_q <= '0;
    end else if (in_detected && (state_q == S_ARMED || state_q == S_CAPTURE)
                 && det_q != 16'hFFFF) begin
      det_q <= det_q + 16'd1;
    end
  end

  assign det_count = det_q;
`else
  logic unused_detected;

  assign unused_detected = in_detected;
  assign det_count       = 16'h0000;
`endif

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;
  assign state    = state_q;

endmodule

// File: tb/tb_spi_capture_buffer.sv
// Scoreboard bench for spi_capture_buffer: a default instance (16/8) and a small one (4/6) for overflow.
module tb_spi_capture_buffer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_detected;
  logic        arm;
  logic [7:0]  trig_value;
  logic [7:0]  trig_mask;
  logic        rd_en;

  logic [7:0]  rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b;
  logic        empty_a, empty_b;
  logic        full_a, full_b;
  logic        overflow_a, overflow_b;
  logic [1:0]  state_a, state_b;
  logic [15:0] det_count_a, det_count_b;

  int          total;
  int          bad;
  logic [7:0]  sb[$];
  logic [7:0]  exp;

`ifdef SPI_CAPBUF_DETCOUNT_EN
  localparam logic [15:0] DET5 = 16'd5;
`else
  localparam logic [15:0] DET5 = 16'd0;
`endif

  spi_capture_buffer #(.DEPTH(16), .CAPTURE_LEN(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_detected(in_detected), .arm(arm), .trig_value(trig_value), .trig_mask(trig_mask),
    .rd_en(rd_en), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .empty(empty_a),
    .full(full_a), .overflow(overflow_a), .state(state_a), .det_count(det_count_a)
  );

  spi_capture_buffer #(.DEPTH(4), .CAPTURE_LEN(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_detected(in_detected), .arm(arm), .trig_value(trig_value), .trig_mask(trig_mask),
    .rd_en(rd_en), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .empty(empty_b),
    .full(full_b), .overflow(overflow_b), .state(state_b), .det_count(det_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    tick();
    tick();
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty_a); end
    total++; if (full_a !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full_a); end
    total++; if (overflow_a !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow_a); end
    total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b want=0", rd_valid_a); end
    total++; if (rd_data_a !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h want=00", rd_data_a); end
    total++; if (det_count_a !== 16'h0) begin bad++; $display("FAIL reset_det got=%h want=0", det_count_a); end
    rst_n = 1'b1;
    tick();
    trig_value = 8'hA5;
    trig_mask  = 8'hFF;
    do_arm();
    send(8'hA5);
    send(8'h01);
    send(8'h02);
    total++; if (state_a !== 2'd2) begin bad++; $display("FAIL midcap_state got=%0d want=2", state_a); end
    total++; if (empty_a !== 1'b0) begin bad++; $display("FAIL midcap_empty got=%b want=0", empty_a); end
    rst_n = 1'b0;
    #1;
    total++; if (state_a !== 2'd0) begin bad++; $display("FAIL areset_state got=%0d want=0", state_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL areset_empty got=%b want=1", empty_a); end
    total++; if (overflow_a !== 1'b0) begin bad++; $display("FAIL areset_overflow got=%b want=0", overflow_a); end
    total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL areset_rd_valid got=%b want=0", rd_valid_a); end
    total++; if (det_count_a !== 16'h0) begin bad++; $display("FAIL areset_det got=%h want=0", det_count_a); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_trigger();
    sb.delete();
    trig_value = 8'hA5;
    trig_mask  = 8'hFF;
    do_arm();
    send(8'h11);
    total++; if (state_a !== 2'd1) begin bad++; $display("FAIL trig_nomatch_state got=%0d want=1", state_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL trig_nomatch_empty got=%b want=1", empty_a); end
    send(8'hA5);
    sb.push_back(8'hA5);
    total++; if (state_a !== 2'd2) begin bad++; $display("FAIL trig_hit_state got=%0d want=2", state_a); end
    for (int i = 1; i <= 7; i++) begin
      send(8'(i));
      sb.push_back(8'(i));
    end
    total++; if (state_a !== 2'd3) begin bad++; $display("FAIL trig_done_state got=%0d want=3", state_a); end
    total++; if (full_a !== 1'b0) begin bad++; $display("FAIL trig_full got=%b want=0", full_a); end
    send(8'hA5);
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      exp = sb.pop_front();
      total++; if (rd_valid_a !== 1'b1 || rd_data_a !== exp) begin
        bad++; $display("FAIL trig_read%0d got=%b/%h want=1/%h", i, rd_valid_a, rd_data_a, exp);
      end
    end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL trig_drained_empty got=%b want=1", empty_a); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL empty_read_valid got=%b want=0", rd_valid_a); end
    total++; if (rd_data_a !== 8'h07) begin bad++; $display("FAIL empty_read_hold got=%h want=07", rd_data_a); end
  endtask

  task automatic test_mask();
    sb.delete();
    trig_value = 8'hA0;
    trig_mask  = 8'hF0;
    do_arm();
    send(8'h3C);
    total++; if (state_a !== 2'd1) begin bad++; $display("FAIL mask_miss_state got=%0d want=1", state_a); end
    send(8'hAF);
    sb.push_back(8'hAF);
    total++; if (state_a !== 2'd2) begin bad++; $display("FAIL mask_hit_state got=%0d want=2", state_a); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    exp = sb.pop_front();
    total++; if (rd_valid_a !== 1'b1 || rd_data_a !== exp) begin
      bad++; $display("FAIL mask_read got=%b/%h want=1/%h", rd_valid_a, rd_data_a, exp);
    end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL mask_empty got=%b want=1", empty_a); end
  endtask

  task automatic test_overflow();
    sb.delete();
    trig_mask = 8'h00;
    do_arm();
    for (int i = 0; i < 6; i++) begin
      send(8'h10 + 8'(i));
      if (i < 4) sb.push_back(8'h10 + 8'(i));
      if (i == 3) begin
        total++; if (full_b !== 1'b1 || overflow_b !== 1'b0 || state_b !== 2'd2) begin
          bad++; $display("FAIL ovf_at_full got=%b/%b/%0d want=1/0/2", full_b, overflow_b, state_b);
        end
      end
    end
    total++; if (full_b !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b want=1", full_b); end
    total++; if (overflow_b !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", overflow_b); end
    total++; if (state_b !== 2'd3) begin bad++; $display("FAIL ovf_state got=%0d want=3", state_b); end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      exp = sb.pop_front();
      total++; if (rd_valid_b !== 1'b1 || rd_data_b !== exp) begin
        bad++; $display("FAIL ovf_read%0d got=%b/%h want=1/%h", i, rd_valid_b, rd_data_b, exp);
      end
    end
    total++; if (empty_b !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b want=1", empty_b); end
  endtask

  task automatic test_full_rdwr();
    sb.delete();
    trig_mask = 8'h00;
    do_arm();
    for (int i = 0; i < 4; i++) begin
      send(8'h20 + 8'(i));
      sb.push_back(8'h20 + 8'(i));
    end
    total++; if (full_b !== 1'b1 || state_b !== 2'd2) begin
      bad++; $display("FAIL rdwr_pre got=%b/%0d want=1/2", full_b, state_b);
    end
    in_data  = 8'h24;
    in_valid = 1'b1;
    rd_en    = 1'b1;
    tick();
    in_valid = 1'b0;
    rd_en    = 1'b0;
    exp = sb.pop_front();
    sb.push_back(8'h24);
    total++; if (rd_valid_b !== 1'b1 || rd_data_b !== exp) begin
      bad++; $display("FAIL rdwr_read got=%b/%h want=1/%h", rd_valid_b, rd_data_b, exp);
    end
    total++; if (full_b !== 1'b1 || overflow_b !== 1'b0) begin
      bad++; $display("FAIL rdwr_flags got=full %b ovf %b want=1/0", full_b, overflow_b);
    end
    total++; if (state_b !== 2'd2) begin bad++; $display("FAIL rdwr_state got=%0d want=2", state_b); end
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      exp = sb.pop_front();
      total++; if (rd_valid_b !== 1'b1 || rd_data_b !== exp) begin
        bad++; $display("FAIL rdwr_drain%0d got=%b/%h want=1/%h", i, rd_valid_b, rd_data_b, exp);
      end
    end
    total++; if (empty_b !== 1'b1) begin bad++; $display("FAIL rdwr_empty got=%b want=1", empty_b); end
  endtask

  task automatic test_back_to_back();
    sb.delete();
    trig_mask = 8'h00;
    do_arm();
    for (int i = 0; i < 8; i++) begin
      send(8'h40 + 8'(i));
      sb.push_back(8'h40 + 8'(i));
    end
    total++; if (state_a !== 2'd3) begin bad++; $display("FAIL b2b_state got=%0d want=3", state_a); end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = sb.pop_front();
      total++; if (rd_valid_a !== 1'b1 || rd_data_a !== exp) begin
        bad++; $display("FAIL b2b_read%0d got=%b/%h want=1/%h", i, rd_valid_a, rd_data_a, exp);
      end
    end
    tick();
    rd_en = 1'b0;
    total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL b2b_past_empty got=%b want=0", rd_valid_a); end
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b want=1", empty_a); end
  endtask

  task automatic test_arm_collision();
    trig_value = 8'h00;
    trig_mask  = 8'hFF;
    do_arm();
    for (int i = 0; i < 5; i++) begin
      in_detected = 1'b1;
      tick();
      in_detected = 1'b0;
      tick();
    end
    total++; if (det_count_a !== DET5) begin bad++; $display("FAIL det_count got=%0d want=%0d", det_count_a, DET5); end
    total++; if (state_a !== 2'd1) begin bad++; $display("FAIL det_state got=%0d want=1", state_a); end
    trig_mask = 8'h00;
    send(8'h55);
    total++; if (empty_a !== 1'b0 || state_a !== 2'd2) begin
      bad++; $display("FAIL coll_pre got=%b/%0d want=0/2", empty_a, state_a);
    end
    arm      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h66;
    rd_en    = 1'b1;
    tick();
    arm      = 1'b0;
    in_valid = 1'b0;
    rd_en    = 1'b0;
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL coll_empty got=%b want=1", empty_a); end
    total++; if (rd_valid_a !== 1'b0) begin bad++; $display("FAIL coll_rd_valid got=%b want=0", rd_valid_a); end
    total++; if (det_count_a !== 16'h0) begin bad++; $display("FAIL coll_det got=%h want=0", det_count_a); end
    total++; if (state_a !== 2'd1) begin bad++; $display("FAIL coll_state got=%0d want=1", state_a); end
    tick();
    total++; if (empty_a !== 1'b1) begin bad++; $display("FAIL coll_discard got=%b want=1", empty_a); end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    in_detected = 1'b0;
    arm         = 1'b0;
    trig_value  = 8'h00;
    trig_mask   = 8'h00;
    rd_en       = 1'b0;
    test_reset();
    test_trigger();
    test_mask();
    test_overflow();
    test_full_rdwr();
    test_back_to_back();
    test_arm_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

endmodule
